// File: rtl/wrr_pifo_queue_if.sv
// Enqueue/dequeue handshake bundle for one per-port WRR PIFO queue.
// The slave side is the queue, the master side is its user.
interface wrr_pifo_queue_if #(
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 enq_valid;
    logic [31:0]          enq_data;
    logic [PAYLOAD_W-1:0] enq_payload;
    logic                 enq_ready;
    logic                 deq_req;
    logic                 deq_valid;
    logic [31:0]          deq_data;
    logic [PAYLOAD_W-1:0] deq_payload;
    logic [CW-1:0]        count;
    logic                 empty;
    logic                 full;
    logic [31:0]          last_pkt_info;
    logic [15:0]          drop_cnt;

    modport master (
        output enq_valid, enq_data, enq_payload, deq_req,
        input  enq_ready, deq_valid, deq_data, deq_payload,
        input  count, empty, full, last_pkt_info, drop_cnt
    );

    modport slave (
        input  enq_valid, enq_data, enq_payload, deq_req,
        output enq_ready, deq_valid, deq_data, deq_payload,
        output count, empty, full, last_pkt_info, drop_cnt
    );
endinterface

// File: rtl/wrr_pifo_queue.sv
// Per-port PIFO: a sorted shift-register array keyed by the wrap-aware
// {overflow, round} field of the rank word; the smallest key is dequeued first.
module wrr_pifo_queue #(
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = 16
) (
    input  logic                  clk_dp,
    input  logic                  rst_n,
    wrr_pifo_queue_if.slave       q_if
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]          data_q    [DEPTH];
    logic [31:0]          data_d    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [CW-1:0]        count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 deq_valid_q, deq_valid_d;
    logic [31:0]          deq_data_q, deq_data_d;
    logic [PAYLOAD_W-1:0] deq_payload_q, deq_payload_d;
    logic [31:0]          last_info_q, last_info_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic [12:0]          key_diff [DEPTH];
    logic [DEPTH-1:0]     precede;
    logic [CW-1:0]        ins_pos;
    logic [CW-1:0]        wr_idx;
    logic                 do_enq;
    logic                 do_deq;

    assign do_enq = q_if.enq_valid && q_if.enq_data[31] && !full_q;
    assign do_deq = q_if.deq_req && !empty_q;

    // New entry precedes slot i when the 13-bit key difference is negative;
    // the lowest such occupied slot wins, otherwise it goes behind everything.
    always_comb begin
        ins_pos = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            key_diff[i] = q_if.enq_data[24:12] - data_q[i][24:12];
            precede[i]  = key_diff[i][12] && (CW'(i) < count_q);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (precede[i]) begin
                ins_pos = CW'(i);
            end
        end
        wr_idx = ins_pos;
        if (do_deq && (ins_pos != '0)) begin
            wr_idx = ins_pos - CW'(1);
        end
    end

    always_comb begin
        data_d    = data_q;
        payload_d = payload_q;

        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_deq && (!do_enq || (CW'(i) < wr_idx))) begin
                data_d[i]    = data_q[i + 1];
                payload_d[i] = payload_q[i + 1];
            end
        end
        if (do_deq && !do_enq) begin
            data_d[DEPTH - 1]    = '0;
            payload_d[DEPTH - 1] = '0;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (do_enq && !do_deq && (CW'(i) > ins_pos)) begin
                data_d[i]    = data_q[i - 1];
                payload_d[i] = payload_q[i - 1];
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (do_enq && (CW'(i) == wr_idx)) begin
                data_d[i]    = q_if.enq_data;
                payload_d[i] = q_if.enq_payload;
            end
        end
    end

    // Occupancy, dequeue port and statistics; full is judged before any dequeue.
    always_comb begin
        count_d       = count_q;
        drop_cnt_d    = drop_cnt_q;
        deq_valid_d   = do_deq;
        deq_data_d    = deq_data_q;
        deq_payload_d = deq_payload_q;
        last_info_d   = last_info_q;

        if (do_enq && !do_deq) begin
            count_d = count_q + CW'(1);
        end else if (do_deq && !do_enq) begin
            count_d = count_q - CW'(1);
        end

        if (q_if.enq_valid && q_if.enq_data[31] && full_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        if (do_deq) begin
            deq_data_d    = data_q[0];
            deq_payload_d = payload_q[0];
            last_info_d   = {1'b1, data_q[0][30:12], 12'h000};
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk_dp or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]    <= '0;
                payload_q[i] <= '0;
            end
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            deq_valid_q   <= 1'b0;
            deq_data_q    <= '0;
            deq_payload_q <= '0;
            last_info_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            data_q        <= data_d;
            payload_q     <= payload_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            deq_valid_q   <= deq_valid_d;
            deq_data_q    <= deq_data_d;
            deq_payload_q <= deq_payload_d;
            last_info_q   <= last_info_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign q_if.enq_ready     = !full_q;
    assign q_if.deq_valid     = deq_valid_q;
    assign q_if.deq_data      = deq_data_q;
    assign q_if.deq_payload   = deq_payload_q;
    assign q_if.count         = count_q;
    assign q_if.empty         = empty_q;
    assign q_if.full          = full_q;
    assign q_if.last_pkt_info = last_info_q;
    assign q_if.drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_wrr_pifo_queue.sv
// Bench for wrr_pifo_queue: directed scenarios plus a random phase, all checked
// against a queue-based reference model of the PIFO ordering rules.
module tb_wrr_pifo_queue;
    localparam int DEPTH     = 16;
    localparam int PAYLOAD_W = 16;

    typedef struct {
        logic [31:0]          d;
        logic [PAYLOAD_W-1:0] p;
    } ent_t;

    logic clk_dp;
    logic rst_n;

    wrr_pifo_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut_if ();

    wrr_pifo_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk_dp (clk_dp),
        .rst_n  (rst_n),
        .q_if   (dut_if)
    );

    ent_t                 mq[$];
    logic                 m_deq_valid;
    logic [31:0]          m_deq_data;
    logic [PAYLOAD_W-1:0] m_deq_payload;
    logic [31:0]          m_last;
    int                   m_drop;
    int                   n_compared;
    int                   n_mismatched;

    initial clk_dp = 1'b0;
    always #5 clk_dp = ~clk_dp;

    function automatic logic [31:0] mk(int cls, int ovf, int rnd, int res);
        logic [31:0] w;
        w = {1'b1, 1'b0, 5'(cls), 2'(ovf), 11'(rnd), 12'(res)};
        return w;
    endfunction

    // Wrap-aware ordering: a is earlier than b when (a - b) mod 8192 lies in the upper half.
    function automatic bit precedes(logic [31:0] a, logic [31:0] b);
        int ka;
        int kb;
        ka = int'(a[24:12]);
        kb = int'(b[24:12]);
        return (((ka - kb) + 8192) % 8192) >= 4096;
    endfunction

    task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        checkValue({tag, ":count"},     32'(dut_if.count), 32'(mq.size()));
        checkValue({tag, ":empty"},     32'(dut_if.empty), 32'(mq.size() == 0));
        checkValue({tag, ":full"},      32'(dut_if.full), 32'(mq.size() == DEPTH));
        checkValue({tag, ":enq_ready"}, 32'(dut_if.enq_ready), 32'(mq.size() != DEPTH));
        checkValue({tag, ":deq_valid"}, 32'(dut_if.deq_valid), 32'(m_deq_valid));
        if (m_deq_valid) begin
            checkValue({tag, ":deq_data"},    dut_if.deq_data, m_deq_data);
            checkValue({tag, ":deq_payload"}, 32'(dut_if.deq_payload), 32'(m_deq_payload));
        end
        checkValue({tag, ":last_pkt_info"}, dut_if.last_pkt_info, m_last);
        checkValue({tag, ":drop_cnt"},      32'(dut_if.drop_cnt), 32'(m_drop));
    endtask

    // One clock of stimulus; the model is advanced from its pre-edge state.
    task automatic applyStimulus(input logic ev, input logic [31:0] ed,
                                 input logic [PAYLOAD_W-1:0] ep, input logic dr,
                                 input string tag);
        bit   was_full;
        bit   take_enq;
        bit   take_deq;
        int   pos;
        ent_t e;
        dut_if.enq_valid   = ev;
        dut_if.enq_data    = ed;
        dut_if.enq_payload = ep;
        dut_if.deq_req     = dr;
        @(posedge clk_dp);
        #1;
        was_full = (mq.size() == DEPTH);
        take_enq = ev && ed[31] && !was_full;
        take_deq = dr && (mq.size() != 0);
        pos = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (precedes(ed, mq[i].d)) begin
                pos = i;
                break;
            end
        end
        if (ev && ed[31] && was_full && m_drop < 65535) m_drop++;
        m_deq_valid = take_deq;
        if (take_deq) begin
            m_deq_data    = mq[0].d;
            m_deq_payload = mq[0].p;
            m_last        = {1'b1, mq[0].d[30:12], 12'h000};
            void'(mq.pop_front());
            if (pos > 0) pos--;
        end
        if (take_enq) begin
            e.d = ed;
            e.p = ep;
            mq.insert(pos, e);
        end
        checkOutput(tag);
    endtask

    task automatic modelReset();
        mq.delete();
        m_deq_valid   = 1'b0;
        m_deq_data    = '0;
        m_deq_payload = '0;
        m_last        = '0;
        m_drop        = 0;
    endtask

    task automatic idleInputs();
        dut_if.enq_valid   = 1'b0;
        dut_if.enq_data    = '0;
        dut_if.enq_payload = '0;
        dut_if.deq_req     = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = mq.size();
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b1, tag);
    endtask

    initial begin
        logic [31:0] w;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b1;
        idleInputs();
        modelReset();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        checkOutput("por");
        checkValue("por:deq_data", dut_if.deq_data, 32'h0);
        @(negedge clk_dp);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle with five entries queued
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk(i, 0, 10 + i, 0), 16'(i), 1'b0, "fill5");
        checkValue("pre_reset:count", 32'(dut_if.count), 32'd5);
        idleInputs();
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset");
        checkValue("midreset:deq_data", dut_if.deq_data, 32'h0);
        @(negedge clk_dp);
        rst_n = 1'b1;

        // Sorting with FIFO ties
        applyStimulus(1'b1, mk(0, 0, 5, 0),      16'h0005, 1'b0, "sort_enq");
        applyStimulus(1'b1, mk(1, 0, 2, 0),      16'h0021, 1'b0, "sort_enq");
        applyStimulus(1'b1, mk(0, 0, 9, 'hABC),  16'h0009, 1'b0, "sort_enq");
        applyStimulus(1'b1, mk(3, 0, 2, 0),      16'h0023, 1'b0, "sort_enq");
        applyStimulus(1'b0, '0, '0, 1'b1, "sort_deq");
        checkValue("sort:first", dut_if.deq_data, mk(1, 0, 2, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "sort_deq");
        checkValue("sort:second", dut_if.deq_data, mk(3, 0, 2, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "sort_deq");
        checkValue("sort:third", dut_if.deq_data, mk(0, 0, 5, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "sort_deq");
        checkValue("sort:fourth", dut_if.deq_data, mk(0, 0, 9, 'hABC));
        checkValue("sort:last_info", dut_if.last_pkt_info, mk(0, 0, 9, 0));

        // Wrap-around ordering
        applyStimulus(1'b1, mk(0, 1, 3, 0),    16'h0103, 1'b0, "wrap1_enq");
        applyStimulus(1'b1, mk(0, 0, 2047, 0), 16'h07FF, 1'b0, "wrap1_enq");
        applyStimulus(1'b0, '0, '0, 1'b1, "wrap1_deq");
        checkValue("wrap1:first", dut_if.deq_data, mk(0, 0, 2047, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "wrap1_deq");
        applyStimulus(1'b1, mk(0, 0, 1, 0),    16'h0001, 1'b0, "wrap2_enq");
        applyStimulus(1'b1, mk(0, 3, 2040, 0), 16'h37F8, 1'b0, "wrap2_enq");
        applyStimulus(1'b0, '0, '0, 1'b1, "wrap2_deq");
        checkValue("wrap2:first", dut_if.deq_data, mk(0, 3, 2040, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "wrap2_deq");

        // Full and drop
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, mk(int'($urandom_range(31)), 0, int'($urandom_range(2047)), 0),
                          16'($urandom), 1'b0, "full_enq");
        end
        checkValue("full:count",     32'(dut_if.count), 32'd16);
        checkValue("full:full",      32'(dut_if.full), 32'd1);
        checkValue("full:enq_ready", 32'(dut_if.enq_ready), 32'd0);
        checkValue("full:drop_cnt",  32'(dut_if.drop_cnt), 32'd1);
        applyStimulus(1'b1, mk(0, 0, 1, 0), 16'hDEAD, 1'b1, "full_enq_deq");
        checkValue("full_enq_deq:count",    32'(dut_if.count), 32'd15);
        checkValue("full_enq_deq:drop_cnt", 32'(dut_if.drop_cnt), 32'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, "full_deq");
        checkValue("after_deq:count",     32'(dut_if.count), 32'd14);
        checkValue("after_deq:enq_ready", 32'(dut_if.enq_ready), 32'd1);
        w = mk(0, 0, 7, 0);
        w[31] = 1'b0;
        applyStimulus(1'b1, w, 16'h0BAD, 1'b0, "invalid_enq");
        checkValue("invalid:count",    32'(dut_if.count), 32'd14);
        checkValue("invalid:drop_cnt", 32'(dut_if.drop_cnt), 32'd2);
        drain("drain_full");

        // Simultaneous enqueue and dequeue
        applyStimulus(1'b1, mk(0, 0, 4, 0), 16'h0004, 1'b0, "simul_enq");
        applyStimulus(1'b1, mk(0, 0, 6, 0), 16'h0006, 1'b0, "simul_enq");
        applyStimulus(1'b1, mk(0, 0, 8, 0), 16'h0008, 1'b0, "simul_enq");
        applyStimulus(1'b1, mk(0, 0, 5, 0), 16'h0005, 1'b1, "simul_both");
        checkValue("simul:deq_data", dut_if.deq_data, mk(0, 0, 4, 0));
        checkValue("simul:count",    32'(dut_if.count), 32'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, "simul_deq");
        checkValue("simul:next1", dut_if.deq_data, mk(0, 0, 5, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "simul_deq");
        checkValue("simul:next2", dut_if.deq_data, mk(0, 0, 6, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "simul_deq");
        checkValue("simul:next3", dut_if.deq_data, mk(0, 0, 8, 0));
        applyStimulus(1'b0, '0, '0, 1'b1, "empty_deq");
        checkValue("empty_deq:deq_valid", 32'(dut_if.deq_valid), 32'd0);

        // Random traffic over the full 13-bit key space
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            w[31] = ($urandom_range(9) != 0);
            applyStimulus($urandom_range(99) < 60, w, 16'($urandom),
                          $urandom_range(99) < 45, "random");
        end
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/wrr_pifo_queue.md
# wrr_pifo_queue

Per-port push-in-first-out (PIFO) queue that consumes the 32-bit rank words produced by the WRR rank calculator. It keeps up to DEPTH entries sorted by wrap-aware rank and dequeues the smallest rank first. It also exports the rank of the last dequeued packet as the `last_pkt_info` word that feeds back into the rank calculator's `wire_in_last_pkt_info<N>` input. One instance is built per output port.

## Interface
- DEPTH, 16: queue entries (power of two, 4..64)
- PAYLOAD_W, 16: opaque packet handle carried with each rank
- clk_dp  in  1  data-plane clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enq_valid  in  1  enqueue strobe, one entry per cycle
- enq_data  in  32  rank word {valid[31], rank[30:12], reserved[11:0]}; rank = {unused, class[4:0], overflow[1:0], round[10:0]}
- enq_payload  in  PAYLOAD_W  handle stored with the entry
- enq_ready  out  1  equals ~full
- deq_req  in  1  dequeue request
- deq_valid  out  1  one-cycle pulse, dequeued entry valid
- deq_data  out  32  rank word of the dequeued entry, unmodified
- deq_payload  out  PAYLOAD_W  handle of the dequeued entry
- count  out  log2(DEPTH)+1  occupancy
- empty  out  1  count==0
- full  out  1  count==DEPTH
- last_pkt_info  out  32  {1'b1, rank of last dequeued entry, 12'h000}
- drop_cnt  out  16  saturating count of enqueues lost because the queue was full

## Operation
- Storage: shift-register array of {data, payload}. Slots 0..count-1 are occupied, sorted, and slot 0 is the head.
- Ordering key: key = rank[12:0] = {overflow, round}, 13 bits.
  - a precedes b iff (a − b) mod 8192 has bit 12 set, i.e. the signed 13-bit difference is negative.
  - Class bits and reserved bits are not used for ordering.
- Insert position: the lowest occupied slot i where the new key precedes key[i]. If there is no such slot, the position is count.
  - Equal keys insert after existing entries, so ties are served FIFO.
- Enqueue acceptance:
  - Accepted when enq_valid && enq_data[31] && !full.
  - enq_valid && !enq_data[31] is ignored and not counted.
  - enq_valid && enq_data[31] && full drops the entry and increments drop_cnt, which saturates at 16'hFFFF.
- Dequeue: deq_req && !empty removes slot 0, and every slot shifts down by one. deq_req while empty is ignored and produces no pulse.
- Simultaneous enqueue and dequeue:
  - The insert position is computed against the pre-dequeue array.
  - The combined operation is a shift-down for slots below the insert position and an in-place write for the rest.
  - count is unchanged.
  - full is evaluated before the dequeue, so an enqueue while full is dropped even when deq_req is high.
- last_pkt_info: on every accepted dequeue it is set to {1'b1, head rank, 12'h000}. Otherwise it holds its value.
- Reset (async, rst_n low): all slots are invalidated and the following outputs take these values:
  - count=0, empty=1, full=0, enq_ready=1
  - deq_valid=0, deq_data=0, deq_payload=0
  - last_pkt_info=32'h0, drop_cnt=0

## Timing
- All state is updated on the posedge of clk_dp. Reset takes effect immediately, independent of the clock, and is released synchronously by the next edge.
- Enqueue latency: an entry accepted at edge N is visible at the head, and therefore dequeueable, by a deq_req sampled at edge N+1.
- Dequeue latency: deq_req sampled at edge N causes the following at edge N, all as registered outputs:
  - deq_valid=1 for the one cycle after edge N
  - deq_data and deq_payload show the head entry
  - last_pkt_info is updated
- Throughput: one enqueue and one dequeue per cycle, sustained.
- count, empty, full and enq_ready are registered and reflect the state after the edge.
- enq_ready has no combinational path from enq_valid or deq_req.
- Comparison and insert-position logic is a DEPTH-wide parallel compare plus a priority encoder. It must close timing at 200 MHz for DEPTH=16.

## Test plan
- Reset: drive rst_n low mid-cycle while count=5.
  - Required immediately: count=0, empty=1, enq_ready=1, deq_valid=0, last_pkt_info=0, drop_cnt=0.
- Sort and ties: enqueue rounds 5, 2 (class 1), 9, 2 (class 3), all overflow=0, then issue 4 dequeues.
  - Required output order: round 2/class 1, round 2/class 3, round 5, round 9.
  - Final last_pkt_info = {1, rank(round 9), 12'h0}.
- Wrap-around, case 1: enqueue {overflow 1, round 3} then {overflow 0, round 2047}.
  - Required: 0/2047 is dequeued first.
- Wrap-around, case 2: enqueue {overflow 0, round 1} then {overflow 3, round 2040}.
  - Required: 3/2040 is dequeued first.
- Full and drop (DEPTH=16): issue 17 valid enqueues.
  - Required: count=16, full=1, enq_ready=0, drop_cnt=1.
  - Then one dequeue: count=15, enq_ready=1.
  - An enqueue issued with enq_data[31]=0 leaves count and drop_cnt unchanged.
- Simultaneous enqueue and dequeue: start with count=3 holding rounds 4, 6, 8; in one cycle enqueue round 5 and assert deq_req.
  - Required: deq_data shows round 4, count stays 3, and the next dequeues return 5, 6, 8.
  - deq_req with empty=1 produces deq_valid=0.
